// File: rtl/axi_rd_sub_ctrl_pkg.sv
// axi_rd_sub_ctrl_pkg: shared AXI encodings, FSM states and captured AR control fields
package axi_rd_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DRAIN = 2'b10
    } rd_state_t;

    // Burst shape captured at the AR handshake; ok=0 marks a request that gets SLVERR beats only
    typedef struct packed {
        axi_burst_t burst;
        logic [2:0] size;
        logic [7:0] len;
        logic       ok;
    } ar_ctl_t;

    // Reserved burst type, oversized beats and non power-of-two WRAP lengths are refused
    function automatic logic ar_legal(input axi_burst_t burst, input logic [2:0] size,
                                      input logic [7:0] len, input logic [2:0] max_size);
        return burst != AXI_BURST_RSVD && size <= max_size &&
               (burst != AXI_BURST_WRAP || len inside {8'd1, 8'd3, 8'd7, 8'd15});
    endfunction

endpackage

// File: rtl/axi_rd_sub_ctrl_if.sv
// axi_rd_sub_ctrl_if: AXI4 read half (AR and R channels) with subordinate and manager views
interface axi_rd_sub_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 3,
    parameter int UW = 32
) ();
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [1:0]    arburst;
    logic [2:0]    arsize;
    logic [7:0]    arlen;
    logic [IW-1:0] arid;
    logic [UW-1:0] aruser;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic [IW-1:0] rid;
    logic          rlast;

    modport r_sub (
        input  arvalid, araddr, arburst, arsize, arlen, arid, aruser, rready,
        output arready, rvalid, rdata, rresp, rid, rlast
    );

    modport r_mgr (
        output arvalid, araddr, arburst, arsize, arlen, arid, aruser, rready,
        input  arready, rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/axi_rd_sub_ctrl_addr_gen.sv
// axi_rd_sub_ctrl_addr_gen: next-beat address for FIXED, INCR and WRAP bursts
module axi_rd_sub_ctrl_addr_gen
    import axi_rd_sub_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  axi_burst_t    burst_i,
    input  logic [2:0]    size_i,
    input  logic [7:0]    len_i,
    output logic [AW-1:0] next_o
);
    logic [AW-1:0] beat_b;
    logic [AW-1:0] win_m;
    logic [AW-1:0] incr;

    // INCR realigns to the beat size; WRAP keeps the upper bits and wraps inside the window
    always_comb begin
        beat_b = AW'(1) << size_i;
        incr   = (addr_i & ~(beat_b - AW'(1))) + beat_b;
        win_m  = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
        next_o = burst_i == AXI_BURST_INCR ? incr :
                 burst_i == AXI_BURST_WRAP ? (addr_i & ~win_m) | ((addr_i + beat_b) & win_m) :
                 addr_i;
    end
endmodule

// File: rtl/axi_rd_sub_ctrl.sv
// axi_rd_sub_ctrl: AXI4 read subordinate turning each AR burst into single-beat component reads
module axi_rd_sub_ctrl
    import axi_rd_sub_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 3,
    parameter int UW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_rd_sub_ctrl_if.r_sub s_axi_r,
    output logic          dv_o,
    output logic [AW-1:0] addr_o,
    output logic [2:0]    size_o,
    output logic [IW-1:0] id_o,
    output logic [UW-1:0] user_o,
    output logic          last_o,
    input  logic          hld_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic          err_i
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    rd_state_t     state_q;
    logic          arready_q;
    logic          rvalid_q;
    logic          rlast_q;
    axi_resp_t     rresp_q;
    logic [IW-1:0] rid_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    ar_ctl_t       ctl_q;
    logic [7:0]    cnt_q;
    logic [IW-1:0] id_q;
    logic [UW-1:0] user_q;
    logic          slot_free;
    logic          fill;

    // The R slot accepts a new beat when empty or being drained this cycle; refused bursts skip the component
    assign slot_free = !rvalid_q || s_axi_r.rready;
    assign dv_o      = state_q == BURST && ctl_q.ok && slot_free;
    assign fill      = state_q == BURST && slot_free && (!ctl_q.ok || !hld_i);

    assign addr_o = addr_q;
    assign size_o = ctl_q.size;
    assign id_o   = id_q;
    assign user_o = user_q;
    assign last_o = cnt_q == 8'd0;

    assign s_axi_r.arready = arready_q;
    assign s_axi_r.rvalid  = rvalid_q;
    assign s_axi_r.rdata   = rdata_q;
    assign s_axi_r.rresp   = rresp_q;
    assign s_axi_r.rid     = rid_q;
    assign s_axi_r.rlast   = rlast_q;

    axi_rd_sub_ctrl_addr_gen #(.AW(AW)) u_addr_gen (
        .addr_i  (addr_q),
        .burst_i (ctl_q.burst),
        .size_i  (ctl_q.size),
        .len_i   (ctl_q.len),
        .next_o  (addr_d)
    );

    // Burst FSM: capture AR, issue one beat per free R slot, then wait for the last beat to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            ctl_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            user_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= !(s_axi_r.arvalid && arready_q);
                    if (s_axi_r.arvalid && arready_q) begin
                        addr_q  <= s_axi_r.araddr;
                        ctl_q   <= '{burst: axi_burst_t'(s_axi_r.arburst), size: s_axi_r.arsize,
                                     len: s_axi_r.arlen,
                                     ok: ar_legal(axi_burst_t'(s_axi_r.arburst), s_axi_r.arsize,
                                                  s_axi_r.arlen, MAX_SIZE)};
                        cnt_q   <= s_axi_r.arlen;
                        id_q    <= s_axi_r.arid;
                        user_q  <= s_axi_r.aruser;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (fill) begin
                        rdata_q  <= ctl_q.ok ? rd_data_i : '0;
                        rresp_q  <= (!ctl_q.ok || err_i) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        rid_q    <= id_q;
                        rlast_q  <= cnt_q == 8'd0;
                        rvalid_q <= 1'b1;
                        addr_q   <= addr_d;
                        cnt_q    <= cnt_q - 8'd1;
                        if (cnt_q == 8'd0) state_q <= DRAIN;
                    end else if (s_axi_r.rready) begin
                        rvalid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (rvalid_q && s_axi_r.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_sub_ctrl.sv
// tb_axi_rd_sub_ctrl: directed scenarios for the AXI read subordinate with hand-computed expectations
module tb_axi_rd_sub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv, last, err;
    logic        hld = 1'b0;
    logic        err_on = 1'b0;
    logic [31:0] addr, user, rd_data;
    logic [31:0] err_addr = '0;
    logic [2:0]  size, id;
    int          errors = 0, checks = 0, cyc = 0, ar_cyc = 0, dv_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [2:0]  id;
        logic        last;
        int          cyc;
    } beat_t;
    beat_t       beat_q[$];
    logic [31:0] acc_q[$];

    axi_rd_sub_ctrl_if #(.AW(32), .DW(32), .IW(3), .UW(32)) axi ();

    axi_rd_sub_ctrl #(.AW(32), .DW(32), .IW(3), .UW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axi_r   (axi),
        .dv_o      (dv),
        .addr_o    (addr),
        .size_o    (size),
        .id_o      (id),
        .user_o    (user),
        .last_o    (last),
        .hld_i     (hld),
        .rd_data_i (rd_data),
        .err_i     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Component model: data encodes the address, error on one selectable address
    assign rd_data = {16'hDA7A, addr[15:0]};
    assign err     = err_on && addr == err_addr;

    // Record completed component reads and R handshakes mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv && !hld) acc_q.push_back(addr);
            if (dv) dv_cnt <= dv_cnt + 1;
            if (axi.rvalid && axi.rready)
                beat_q.push_back('{axi.rdata, axi.rresp, axi.rid, axi.rlast, cyc});
        end
    end

    task automatic send_ar(input logic [31:0] a, input logic [1:0] b, input logic [2:0] s,
                           input logic [7:0] l, input logic [2:0] i);
        beat_q.delete();
        acc_q.delete();
        axi.araddr  = a;
        axi.arburst = b;
        axi.arsize  = s;
        axi.arlen   = l;
        axi.arid    = i;
        axi.aruser  = 32'hCAFE_0000 | 32'(i);
        axi.arvalid = 1'b1;
        for (int n = 0; n < 50 && !axi.arready; n++) begin
            @(posedge clk);
            #1;
        end
        ar_cyc = cyc;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake addr=%h arready=%b want 1", a, axi.arready);
        end
        @(posedge clk);
        #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int t = 0; t < 200 && beat_q.size() < n; t++) @(posedge clk);
        #1;
        checks++;
        if (beat_q.size() != n) begin
            errors++;
            $display("FAIL beat_count got %0d want %0d", beat_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({axi.arready, axi.rvalid, axi.rlast, dv} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl arready/rvalid/rlast/dv=%b want 0000",
                     {axi.arready, axi.rvalid, axi.rlast, dv});
        end
        checks++;
        if ({axi.rresp, axi.rid, axi.rdata} !== 37'b0) begin
            errors++;
            $display("FAIL reset_data rresp=%h rid=%h rdata=%h want 0", axi.rresp, axi.rid, axi.rdata);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (axi.arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release arready=%b want 0", axi.arready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_clk arready=%b want 1", axi.arready);
        end
    endtask

    task automatic test_incr();
        logic [31:0] ea;
        send_ar(32'h100, 2'b01, 3'd2, 8'd3, 3'd1);
        wait_beats(4);
        checks++;
        if (acc_q.size() != 4) begin
            errors++;
            $display("FAIL incr_acc_count got %0d want 4", acc_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            ea = 32'h100 + 32'(4 * i);
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== ea || i >= beat_q.size() ||
                beat_q[i].data !== {16'hDA7A, ea[15:0]} || beat_q[i].resp !== 2'b00 ||
                beat_q[i].last !== (i == 3) || beat_q[i].id !== 3'd1 || beat_q[i].cyc != ar_cyc + 2 + i) begin
                errors++;
                $display("FAIL incr_beat%0d addr=%h data=%h resp=%b last=%b cyc=%0d want addr=%h last=%b cyc=%0d",
                         i, i < acc_q.size() ? acc_q[i] : 32'hx, i < beat_q.size() ? beat_q[i].data : 32'hx,
                         i < beat_q.size() ? beat_q[i].resp : 2'bx, i < beat_q.size() ? beat_q[i].last : 1'bx,
                         i < beat_q.size() ? beat_q[i].cyc : -1, ea, i == 3, ar_cyc + 2 + i);
            end
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] exp_a [2];
        exp_a[0] = 32'h102;
        exp_a[1] = 32'h104;
        send_ar(32'h102, 2'b01, 3'd2, 8'd1, 3'd0);
        wait_beats(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL unaligned_addr%0d got %h want %h", i, i < acc_q.size() ? acc_q[i] : 32'hx, exp_a[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h1C;
        exp_a[1] = 32'h10;
        exp_a[2] = 32'h14;
        exp_a[3] = 32'h18;
        send_ar(32'h1C, 2'b10, 3'd2, 8'd3, 3'd5);
        wait_beats(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_a[i] || i >= beat_q.size() ||
                beat_q[i].id !== 3'd5 || beat_q[i].last !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d addr=%h rid=%h last=%b want addr=%h rid=5 last=%b",
                         i, i < acc_q.size() ? acc_q[i] : 32'hx, i < beat_q.size() ? beat_q[i].id : 3'bx,
                         i < beat_q.size() ? beat_q[i].last : 1'bx, exp_a[i], i == 3);
            end
        end
    endtask

    task automatic test_fixed_backpressure();
        send_ar(32'h40, 2'b00, 3'd2, 8'd2, 3'd3);
        for (int t = 0; t < 20 && !(axi.rvalid && axi.rready); t++) @(negedge clk);
        @(posedge clk);
        #1;
        axi.rready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hDA7A_0040 || axi.rlast !== 1'b0 || dv !== 1'b0) begin
                errors++;
                $display("FAIL fixed_hold rvalid=%b rdata=%h rlast=%b dv=%b want 1 da7a0040 0 0",
                         axi.rvalid, axi.rdata, axi.rlast, dv);
            end
        end
        @(posedge clk);
        #1;
        axi.rready = 1'b1;
        wait_beats(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== 32'h40 || i >= beat_q.size() ||
                beat_q[i].data !== 32'hDA7A_0040 || beat_q[i].last !== (i == 2)) begin
                errors++;
                $display("FAIL fixed_beat%0d addr=%h data=%h last=%b want 00000040 da7a0040 %b",
                         i, i < acc_q.size() ? acc_q[i] : 32'hx, i < beat_q.size() ? beat_q[i].data : 32'hx,
                         i < beat_q.size() ? beat_q[i].last : 1'bx, i == 2);
            end
        end
    endtask

    task automatic test_hld_err();
        logic [1:0] exp_r [4];
        exp_r[0] = 2'b00;
        exp_r[1] = 2'b00;
        exp_r[2] = 2'b10;
        exp_r[3] = 2'b00;
        err_addr = 32'h208;
        err_on   = 1'b1;
        hld      = 1'b1;
        send_ar(32'h200, 2'b01, 3'd2, 8'd3, 3'd2);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (dv !== 1'b1 || addr !== 32'h200 || size !== 3'd2 || id !== 3'd2 ||
                user !== 32'hCAFE_0002 || last !== 1'b0) begin
                errors++;
                $display("FAIL hld_stable dv=%b addr=%h size=%0d id=%0d user=%h last=%b want 1 200 2 2 cafe0002 0",
                         dv, addr, size, id, user, last);
            end
        end
        @(posedge clk);
        #1;
        hld = 1'b0;
        wait_beats(4);
        err_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= beat_q.size() || beat_q[i].resp !== exp_r[i] ||
                beat_q[i].data !== {16'hDA7A, 16'h0200 + 16'(4 * i)}) begin
                errors++;
                $display("FAIL hld_err_beat%0d resp=%b data=%h want resp=%b",
                         i, i < beat_q.size() ? beat_q[i].resp : 2'bx,
                         i < beat_q.size() ? beat_q[i].data : 32'hx, exp_r[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int dv0;
        dv0 = dv_cnt;
        send_ar(32'h300, 2'b11, 3'd2, 8'd1, 3'd3);
        wait_beats(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= beat_q.size() || beat_q[i].resp !== 2'b10 || beat_q[i].data !== 32'h0 ||
                beat_q[i].last !== (i == 1) || beat_q[i].id !== 3'd3) begin
                errors++;
                $display("FAIL illegal_burst_beat%0d resp=%b data=%h last=%b want 10 0 %b",
                         i, i < beat_q.size() ? beat_q[i].resp : 2'bx,
                         i < beat_q.size() ? beat_q[i].data : 32'hx, i < beat_q.size() ? beat_q[i].last : 1'bx, i == 1);
            end
        end
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_burst_arready got %b want 1", axi.arready);
        end
        send_ar(32'h400, 2'b01, 3'd3, 8'd2, 3'd4);
        wait_beats(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= beat_q.size() || beat_q[i].resp !== 2'b10 || beat_q[i].data !== 32'h0 ||
                beat_q[i].last !== (i == 2) || beat_q[i].id !== 3'd4) begin
                errors++;
                $display("FAIL illegal_size_beat%0d resp=%b data=%h last=%b want 10 0 %b",
                         i, i < beat_q.size() ? beat_q[i].resp : 2'bx,
                         i < beat_q.size() ? beat_q[i].data : 32'hx, i < beat_q.size() ? beat_q[i].last : 1'bx, i == 2);
            end
        end
        checks++;
        if (axi.arready !== 1'b1 || dv_cnt != dv0) begin
            errors++;
            $display("FAIL illegal_size_end arready=%b dv_cycles=%0d want 1 0", axi.arready, dv_cnt - dv0);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        send_ar(32'h500, 2'b01, 3'd2, 8'd7, 3'd6);
        for (int t = 0; t < 40 && k < 2; t++) begin
            @(negedge clk);
            if (axi.rvalid && axi.rready) k++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (axi.rvalid !== 1'b0 || dv !== 1'b0 || axi.arready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset rvalid=%b dv=%b arready=%b want 000", axi.rvalid, dv, axi.arready);
        end
        beat_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (axi.rvalid !== 1'b0 || beat_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet rvalid=%b beats=%0d want 0 0", axi.rvalid, beat_q.size());
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_arready got %b want 1", axi.arready);
        end
        send_ar(32'h600, 2'b01, 3'd2, 8'd1, 3'd7);
        wait_beats(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= beat_q.size() || beat_q[i].data !== {16'hDA7A, 16'h0600 + 16'(4 * i)} ||
                beat_q[i].id !== 3'd7 || beat_q[i].last !== (i == 1) || beat_q[i].resp !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_beat%0d data=%h id=%h last=%b resp=%b",
                         i, i < beat_q.size() ? beat_q[i].data : 32'hx, i < beat_q.size() ? beat_q[i].id : 3'bx,
                         i < beat_q.size() ? beat_q[i].last : 1'bx, i < beat_q.size() ? beat_q[i].resp : 2'bx);
            end
        end
    endtask

    initial begin
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.arburst = '0;
        axi.arsize  = '0;
        axi.arlen   = '0;
        axi.arid    = '0;
        axi.aruser  = '0;
        axi.rready  = 1'b1;
        test_reset();
        test_incr();
        test_unaligned();
        test_wrap();
        test_fixed_backpressure();
        test_hld_err();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
